// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: data width, opcodes,
// instruction field positions and the execute FSM state type.
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hC;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int RD_MSB = 3;
    localparam int RD_LSB = 2;
    localparam int RS_MSB = 1;
    localparam int RS_LSB = 0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        IMM  = 2'd1,
        MUL  = 2'd2,
        HALT = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul8.sv
// Iterative 8x8 shift-add multiplier. Operands are captured on start; one
// partial product is accumulated per cycle over eight cycles. done is high
// during the eighth cycle, when product already carries the full result.
module alu_mul8
    import alu_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [ALU_W-1:0]     a,
    input  logic [ALU_W-1:0]     b,
    output logic [2*ALU_W-1:0]   product,
    output logic                 done
);

    logic [2*ALU_W-1:0] r_mcand;
    logic [ALU_W-1:0]   r_mplier;
    logic [2*ALU_W-1:0] r_acc;
    logic [2:0]         r_cnt;
    logic               r_busy;
    logic [2*ALU_W-1:0] w_sum;

    // Accumulator plus the current partial product (multiplicand if the low multiplier bit is set)
    always_comb begin
        w_sum = r_acc;
        if (r_mplier[0]) begin
            w_sum = r_acc + r_mcand;
        end
    end

    // Capture operands on start, then shift and accumulate one bit per cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{ALU_W{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign product = w_sum;
    assign done    = r_busy && (r_cnt == 3'd7);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: decodes the instruction byte stream, runs it against a
// 4x8 register file, keeps Z/C flags and drives the OUT port. LDI takes a
// second raw byte, MUL is handed to the iterative multiplier.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [7:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_c,
    output logic             halted,
    output logic             illegal
);

    state_t             r_state;
    state_t             w_next_state;
    logic [ALU_W-1:0]   r_regs [4];
    logic [1:0]         r_dest_rd;
    logic               r_flag_z;
    logic               r_flag_c;
    logic               r_out_valid;
    logic [ALU_W-1:0]   r_out_data;
    logic               r_illegal;

    logic               w_accept;
    logic               w_run_accept;
    logic [3:0]         w_op;
    logic [1:0]         w_rd;
    logic [1:0]         w_rs;
    logic [ALU_W-1:0]   w_opa;
    logic [ALU_W-1:0]   w_opb;
    logic [ALU_W:0]     w_sum9;
    logic [ALU_W-1:0]   w_res;
    logic               w_carry;
    logic               w_wr_en;
    logic               w_flag_en;
    logic               w_is_out;
    logic               w_is_illegal;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*ALU_W-1:0] w_product;

    assign instr_ready  = (r_state == RUN) || (r_state == IMM);
    assign w_accept     = instr_valid && instr_ready;
    assign w_run_accept = w_accept && (r_state == RUN);
    assign w_op         = instr[OP_MSB:OP_LSB];
    assign w_rd         = instr[RD_MSB:RD_LSB];
    assign w_rs         = instr[RS_MSB:RS_LSB];
    assign w_opa        = r_regs[w_rd];
    assign w_opb        = r_regs[w_rs];

    alu_mul8 u_mul (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (w_mul_start),
        .a       (w_opa),
        .b       (w_opb),
        .product (w_product),
        .done    (w_mul_done)
    );

    // Decode an accepted RUN-state byte into a result, carry and write/flag enables
    always_comb begin
        w_sum9       = '0;
        w_res        = '0;
        w_carry      = 1'b0;
        w_wr_en      = 1'b0;
        w_flag_en    = 1'b0;
        w_is_out     = 1'b0;
        w_is_illegal = 1'b0;
        w_mul_start  = 1'b0;
        if (w_run_accept) begin
            case (w_op)
                OP_ADD: begin
                    w_sum9    = {1'b0, w_opa} + {1'b0, w_opb};
                    w_res     = w_sum9[ALU_W-1:0];
                    w_carry   = w_sum9[ALU_W];
                    w_wr_en   = 1'b1;
                    w_flag_en = 1'b1;
                end
                OP_SUB: begin
                    w_sum9    = {1'b0, w_opa} - {1'b0, w_opb};
                    w_res     = w_sum9[ALU_W-1:0];
                    w_carry   = w_sum9[ALU_W];
                    w_wr_en   = 1'b1;
                    w_flag_en = 1'b1;
                end
                OP_AND: begin
                    w_res     = w_opa & w_opb;
                    w_wr_en   = 1'b1;
                    w_flag_en = 1'b1;
                end
                OP_OR: begin
                    w_res     = w_opa | w_opb;
                    w_wr_en   = 1'b1;
                    w_flag_en = 1'b1;
                end
                OP_XOR: begin
                    w_res     = w_opa ^ w_opb;
                    w_wr_en   = 1'b1;
                    w_flag_en = 1'b1;
                end
                OP_MOV: begin
                    w_res     = w_opb;
                    w_wr_en   = 1'b1;
                end
                OP_SHL: begin
                    w_res     = {w_opa[ALU_W-2:0], 1'b0};
                    w_carry   = w_opa[ALU_W-1];
                    w_wr_en   = 1'b1;
                    w_flag_en = 1'b1;
                end
                OP_SHR: begin
                    w_res     = {1'b0, w_opa[ALU_W-1:1]};
                    w_carry   = w_opa[0];
                    w_wr_en   = 1'b1;
                    w_flag_en = 1'b1;
                end
                OP_MUL: begin
                    w_mul_start = 1'b1;
                end
                OP_OUT: begin
                    w_is_out = 1'b1;
                end
                OP_NOP, OP_LDI, OP_HLT: begin
                end
                default: begin
                    w_is_illegal = 1'b1;
                end
            endcase
        end
    end

    // Next-state logic: LDI and MUL leave RUN temporarily, HLT (and optionally illegal) stick in HALT
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (w_run_accept) begin
                    if (w_op == OP_LDI) begin
                        w_next_state = IMM;
                    end else if (w_op == OP_MUL) begin
                        w_next_state = MUL;
                    end else if (w_op == OP_HLT) begin
                        w_next_state = HALT;
                    end else if (w_is_illegal && HALT_ON_ILLEGAL) begin
                        w_next_state = HALT;
                    end
                end
            end
            IMM: begin
                if (w_accept) begin
                    w_next_state = RUN;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_next_state = RUN;
                end
            end
            HALT: begin
                w_next_state = HALT;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember the destination register of an LDI or MUL for its later write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dest_rd <= '0;
        end else if (w_run_accept) begin
            r_dest_rd <= w_rd;
        end
    end

    // Register file: single-cycle results, LDI data byte, and multiplier result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_regs[w_rd] <= w_res;
            end
            if ((r_state == IMM) && w_accept) begin
                r_regs[r_dest_rd] <= instr;
            end
            if ((r_state == MUL) && w_mul_done) begin
                r_regs[r_dest_rd] <= w_product[ALU_W-1:0];
            end
        end
    end

    // Zero and carry flags, updated by ALU ops and on multiplier completion
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_flag_en) begin
            r_flag_z <= (w_res == '0);
            r_flag_c <= w_carry;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_flag_z <= (w_product[ALU_W-1:0] == '0);
            r_flag_c <= (w_product[2*ALU_W-1:ALU_W] != '0);
        end
    end

    // OUT port and one-cycle status pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= w_is_out;
            r_illegal   <= w_is_illegal;
            if (w_is_out) begin
                r_out_data <= w_opb;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign illegal   = r_illegal;
    assign halted    = (r_state == HALT);

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute stage of the ALU datapath: consumes the 8-bit instruction byte stream produced by the instruction pop stage, decodes it, and executes it against a 4×8-bit register file. Produces result bytes on an output port and maintains zero and carry flags. Supports single-cycle ops, a two-byte load-immediate, a multi-cycle shift-add multiply, and halt; back-pressure is via `instr_ready`.

## Interface
- `HALT_ON_ILLEGAL`, default 0: if 1, an undefined opcode enters HALT; if 0, it executes as NOP.
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `instr`  in  8  instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs.
- `instr_valid`  in  1  `instr` holds a byte this cycle.
- `instr_ready`  out  1  unit accepts a byte this cycle; transfer when `instr_valid && instr_ready` at the edge.
- `out_data`  out  8  last value emitted by OUT.
- `out_valid`  out  1  one-cycle pulse when `out_data` updates.
- `flag_z`, `flag_c`  out  1 each  zero and carry flags.
- `halted`  out  1  unit is in HALT.
- `illegal`  out  1  one-cycle pulse on accepting an undefined opcode.

## Operation
- States: RUN, IMM, MUL, HALT. Reset state is RUN.
- Opcodes:
  - 0x0 NOP.
  - 0x1 ADD: rd = rd + rs.
  - 0x2 SUB: rd = rd − rs.
  - 0x3 AND, 0x4 OR, 0x5 XOR: rd = rd op rs.
  - 0x6 MOV: rd = rs.
  - 0x7 SHL rd; 0x8 SHR rd (logical, 1 bit, rs ignored).
  - 0x9 LDI rd: next accepted byte → rd.
  - 0xA MUL: rd = low8(rd × rs).
  - 0xB OUT: out_data = R[rs].
  - 0xC HLT.
  - 0xD–0xF undefined.
- Flags, Z: for ADD/SUB/AND/OR/XOR/SHL/SHR/MUL, Z = (8-bit result == 0).
- Flags, C:
  - ADD: carry out of bit 7.
  - SUB: borrow (rd < rs unsigned).
  - AND/OR/XOR: C cleared.
  - SHL: old bit 7. SHR: old bit 0.
  - MUL: high byte of the 16-bit product ≠ 0.
- Flags unchanged by NOP, MOV, LDI, OUT, HLT and undefined opcodes.
- All arithmetic is 8-bit modulo; ADD/SUB use a 9-bit internal sum.
- RUN → IMM on LDI. In IMM, the next accepted byte is raw data, never decoded; written to the latched rd, then → RUN. `instr_valid` low in IMM keeps IMM indefinitely.
- RUN → MUL on MUL. Operands are latched at accept. The `alu_mul8` sub-module iterates 8 cycles, writes rd and flags on the last MUL edge, then → RUN.
- RUN → HALT on HLT, or on an undefined opcode when `HALT_ON_ILLEGAL` = 1. HALT is exited only by reset.
- Undefined opcode: `illegal` pulses for one cycle regardless of `HALT_ON_ILLEGAL`.
- rd == rs is legal for every op; both operands read the pre-instruction value.

## Timing
- Reset values:
  - R0–R3 = 0x00; `out_data` = 0x00.
  - `out_valid`, `illegal`, `flag_z`, `flag_c`, `halted` = 0.
  - `instr_ready` = 1.
- `instr_ready` is a combinational decode of state: 1 in RUN and IMM, 0 in MUL and HALT.
- Single-cycle ops: register/flag result is visible the cycle after the accepting edge. Back-to-back dependent instructions need no stall.
- OUT: `out_data` updates and `out_valid` = 1 for exactly the cycle after the accepting edge.
- MUL: `instr_ready` is low for exactly 8 cycles after the accepting edge. Result is visible on the cycle `instr_ready` returns high.
- `illegal` is high for the one cycle after acceptance.
- Asserting `RST_N` low mid-MUL or mid-IMM aborts the operation immediately. No partial write; all outputs take reset values asynchronously.
- Bytes presented while `instr_ready` = 0 are not consumed; the upstream holds them.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_HLT`);
  - the state enum (RUN/IMM/MUL/HALT);
  - instruction field bit positions;
  - constant `ALU_W` = 8.
- Sub-module `alu_mul8`: 8×8 shift-add multiplier.
  - Inputs: `start`, operands.
  - Outputs: 16-bit `product`, `done` pulse on cycle 8.
  - Clocked by `CLK`, reset by `RST_N`.
- Top level holds decode, register file, flags, FSM and output registers.

## Test plan
- LDI R0 (0x90, 0x0F), LDI R1 (0x94, 0xF1), ADD (0x11), OUT R0 (0xB0) → R0 = 0x00, Z = 1, C = 1; `out_valid` pulses once with `out_data` = 0x00.
- R2 = 0x10, R3 = 0x11, MUL (0xAB) → `instr_ready` low exactly 8 cycles, then R2 = 0x10, C = 1, Z = 0.
- LDI R3 (0x9C), hold `instr_valid` low 3 cycles, then 0xA5 → state stays IMM during the gap; R3 = 0xA5; 0xA5 is not decoded as MUL.
- Undefined opcode 0xD0 with `HALT_ON_ILLEGAL` = 0 → `illegal` pulses one cycle, registers/flags unchanged, next byte accepted. Repeat with `HALT_ON_ILLEGAL` = 1 → `halted` = 1, `instr_ready` = 0.
- HLT (0xC0), then stream ADDs → none accepted, registers unchanged. Pulse `RST_N` low → all reset values, `instr_ready` = 1.
- Drop `RST_N` during cycle 4 of MUL → rd keeps 0x00 (reset value), state RUN, `alu_mul8` idle after release.
